booth_mult_signed: RTL and testbench

- Sequential radix-2 Booth multiplier for signed two's-complement operands. It is the inverse companion of the team's sequential signed restoring divider.
- It shares the same N parameter and the same one-bit-per-cycle iteration style.
- It produces a full 2N-bit signed product.
- It uses a start/busy/done handshake so datapath controllers can sequence multiply and divide operations the same way.

---
 rtl/booth_mult_signed.sv | 88 ++++++++
 tb/tb_booth_mult_signed.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/booth_mult_signed.sv
// Sequential radix-2 Booth multiplier for signed two's-complement operands.
// One Booth iteration per clock; start/busy/done handshake matches the signed divider.
module booth_mult_signed #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   mcand_in,
  input  logic [N-1:0]   mplier_in,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(N + 1);

  state_t         state, state_next;
  logic [N:0]     m_reg;
  logic [N:0]     a_reg;
  logic [N-1:0]   q_reg;
  logic           q_m1;
  logic [CW-1:0]  cnt;

  logic [N:0]     a_sum;
  logic [N:0]     a_next;
  logic [N-1:0]   q_next;
  logic           q_m1_next;
  logic           accept;
  logic           last_iter;

  assign accept    = start && (state != CALC);
  assign last_iter = (state == CALC) && (cnt == CW'(1));
  assign busy      = (state == CALC);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = accept ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A and M carry an extra bit so subtracting the most-negative multiplicand cannot overflow
  always_comb begin
    a_sum = a_reg;
    case ({q_reg[0], q_m1})
      2'b01:   a_sum = a_reg + m_reg;
      2'b10:   a_sum = a_reg - m_reg;
      default: a_sum = a_reg;
    endcase
    {a_next, q_next, q_m1_next} = {a_sum[N], a_sum, q_reg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg   <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      m_reg <= {mcand_in[N-1], mcand_in};
      a_reg <= '0;
      q_reg <= mplier_in;
      q_m1  <= 1'b0;
      cnt   <= CW'(N);
    end else if (state == CALC) begin
      a_reg <= a_next;
      q_reg <= q_next;
      q_m1  <= q_m1_next;
      cnt   <= cnt - CW'(1);
      if (last_iter) product <= {a_next[N-1:0], q_next};
    end
  end

endmodule

// File: tb/tb_booth_mult_signed.sv
// Testbench for booth_mult_signed: directed N=4 handshake/corner cases and
// back-to-back random N=8 operations against an integer-multiply reference.
module tb_booth_mult_signed;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start4;
  logic [3:0]  mc4, mp4;
  logic        busy4, done4;
  logic [7:0]  prod4;

  logic        start8;
  logic [7:0]  mc8, mp8;
  logic        busy8, done8;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;

  booth_mult_signed #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mcand_in(mc4), .mplier_in(mp4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  booth_mult_signed #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mcand_in(mc8), .mplier_in(mp8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  // Accepts one operation; operands are scrambled afterwards to prove they are sampled only once
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    mc4 = a;
    mp4 = b;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    mc4 = 4'($urandom);
    mp4 = 4'($urandom);
    checkBit("accept_busy", busy4, 1'b1);
  endtask

  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [7:0] expv);
    applyStimulus(a, b);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 4) begin
        checkBit({tag, "_busy"}, busy4, 1'b1);
        checkBit({tag, "_early_done"}, done4, 1'b0);
      end
    end
    checkBit({tag, "_done"}, done4, 1'b1);
    checkBit({tag, "_busy_low"}, busy4, 1'b0);
    checkOutput({tag, "_prod"}, 16'(prod4), 16'(expv));
    @(posedge clk);
    #1;
    checkBit({tag, "_done_pulse"}, done4, 1'b0);
  endtask

  logic signed [7:0] ra, rb;
  logic [15:0]       expv8;
  int                cyc;

  initial begin
    rst = 1'b1;
    start4 = 1'b0; mc4 = '0; mp4 = '0;
    start8 = 1'b0; mc8 = '0; mp8 = '0;
    #12;
    checkBit("reset_busy", busy4, 1'b0);
    checkBit("reset_done", done4, 1'b0);
    checkOutput("reset_prod4", 16'(prod4), 16'h0000);
    checkOutput("reset_prod8", prod8, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    run4("p3x5", 4'h3, 4'h5, 8'h0F);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("p3x5_hold", 16'(prod4), 16'h000F);

    run4("m3x5", 4'hD, 4'h5, 8'hF1);
    run4("m8xm8", 4'h8, 4'h8, 8'h40);
    run4("m8x7", 4'h8, 4'h7, 8'hC8);
    run4("p7xm1", 4'h7, 4'hF, 8'hF9);
    run4("z0xm8", 4'h0, 4'h8, 8'h00);

    // start held high: the mid-op start is ignored, the DONE-cycle start is accepted
    @(negedge clk);
    mc4 = 4'h3; mp4 = 4'h3; start4 = 1'b1;
    @(posedge clk);
    #1;
    mc4 = 4'h2; mp4 = 4'h2;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 4) checkBit("hold_early_done", done4, 1'b0);
    end
    checkBit("hold_done", done4, 1'b1);
    checkOutput("hold_prod", 16'(prod4), 16'h0009);
    @(posedge clk);
    #1;
    start4 = 1'b0;
    checkBit("b2b_done_pulse", done4, 1'b0);
    checkBit("b2b_busy", busy4, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 4) checkBit("b2b_early_done", done4, 1'b0);
    end
    checkBit("b2b_done", done4, 1'b1);
    checkOutput("b2b_prod", 16'(prod4), 16'h0004);

    // asynchronous reset two iterations into an operation
    applyStimulus(4'h7, 4'h7);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkBit("arst_busy", busy4, 1'b0);
    checkBit("arst_done", done4, 1'b0);
    checkOutput("arst_prod", 16'(prod4), 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkBit("arst_no_done", done4, 1'b0);
    end
    run4("p7x7", 4'h7, 4'h7, 8'h31);

    // N=8: back-to-back random pairs, corners first
    @(negedge clk);
    for (int n = 0; n < 1000; n++) begin
      if (n == 0) begin ra = -8'sd128; rb = -8'sd128; end
      else if (n == 1) begin ra = -8'sd128; rb = 8'sd127; end
      else begin ra = 8'($urandom); rb = 8'($urandom); end
      expv8 = 16'(int'(ra) * int'(rb));
      mc8 = ra; mp8 = rb; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      mc8 = 8'($urandom); mp8 = 8'($urandom);
      cyc = 0;
      do begin
        @(posedge clk);
        #1;
        cyc++;
      end while (!done8 && cyc < 20);
      checkBit("r8_done", done8, 1'b1);
      checkOutput("r8_latency", 16'(cyc), 16'd8);
      checkOutput("r8_prod", prod8, expv8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
